// File: rtl/nes_controller_reader.sv
// NES pad reader: drives latch/serial clock to the pad's shift register and
// collects the 8 button bits into a registered parallel word.
`timescale 1ns/1ps

module nes_controller_reader #(
    parameter int HALF_CYCLES = 300,
    parameter int POLL_CYCLES = 833333,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll_en,
    input  logic       poll_now,
    input  logic       data,
    output logic       latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PHASE_W = $clog2(2 * HALF_CYCLES);
    localparam int POLL_W  = $clog2(POLL_CYCLES);
    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic               timer_hit_q, timer_hit_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         sync_q, sync_d;
    logic [7:0]         buttons_q, buttons_d;
    logic               latch_q, latch_d;
    logic               nes_clk_q, nes_clk_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            poll_cnt_q  <= '0;
            timer_hit_q <= 1'b0;
            phase_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync_q      <= '0;
            buttons_q   <= '0;
            latch_q     <= 1'b0;
            nes_clk_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            timer_hit_q <= timer_hit_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            buttons_q   <= buttons_d;
            latch_q     <= latch_d;
            nes_clk_q   <= nes_clk_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = poll_cnt_q;
        timer_hit_d = 1'b0;
        phase_d     = phase_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        buttons_d   = buttons_q;
        sync_d      = {sync_q[0], data};

        case (state_q)
            IDLE: begin
                // Timer expiry is registered, so the poll starts one cycle after the count hits its end.
                if (poll_now || timer_hit_q) begin
                    state_d    = LATCH;
                    poll_cnt_d = '0;
                    phase_d    = '0;
                end else if (!poll_en) begin
                    poll_cnt_d = '0;
                end else begin
                    timer_hit_d = (poll_cnt_q == POLL_LAST);
                    if (poll_cnt_q != POLL_LAST) begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    end
                end
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d   = LOW;
                    phase_d   = '0;
                    bit_idx_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            LOW: begin
                if (phase_q == HALF_LAST) begin
                    shift_d[bit_idx_q] = sync_q[1];
                    state_d            = HIGH;
                    phase_d            = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            HIGH: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        // Word is complete; publish it alongside the valid pulse.
                        state_d   = DONE;
                        buttons_d = ACTIVE_LOW ? ~shift_q : shift_q;
                    end else begin
                        state_d   = LOW;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                poll_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        latch_d   = (state_d == LATCH);
        nes_clk_d = (state_d == HIGH);
        valid_d   = (state_d == DONE);
        busy_d    = (state_d != IDLE);
    end

    assign latch   = latch_q;
    assign nes_clk = nes_clk_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;
    assign busy    = busy_q;

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
Console-side NES pad interface. It generates the latch and serial clock pulses that drive the pad's parallel-to-serial stage, and shifts in the 8 serial data bits. It then presents them as a registered parallel button word to game/control logic. It sits directly upstream of the pad's latch/clk inputs and downstream of its data output.

Parameters:
HALF_CYCLES, 300, system clocks per half-period of the serial clock; latch width is 2*HALF_CYCLES; legal range >= 4.
POLL_CYCLES, 833333, idle system clocks between automatic polls; legal range >= 2.
ACTIVE_LOW, 0, 1 = invert sampled data so pressed = 1 in buttons.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
poll_en  in  1  enables periodic polling
poll_now  in  1  single-cycle request for an immediate poll
data  in  1  serial data from the pad; asynchronous, passed through a 2-flop synchronizer
latch  out  1  latch pulse to the pad
nes_clk  out  1  serial shift clock to the pad
buttons  out  8  bit0 A, bit1 B, bit2 select, bit3 start, bit4 up, bit5 down, bit6 left, bit7 right
valid  out  1  one-cycle pulse when buttons updates
busy  out  1  high while a transaction is in progress

Behaviour:
- Reset (async, active-high): latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0. State goes to IDLE. Poll counter, phase counter, bit index, shift register and synchronizer all clear. Reset mid-transaction aborts it; buttons is not updated.
- All outputs are registered.
- States: IDLE, LATCH, LOW, HIGH, DONE.
- IDLE:
  - poll counter increments each cycle while poll_en=1 and holds at 0 while poll_en=0.
  - Transition to LATCH on the cycle after either the counter reaches POLL_CYCLES-1 or poll_now=1.
  - The counter clears on that transition.
  - Simultaneous expiry and poll_now start exactly one transaction.
  - poll_now outside IDLE is ignored (not queued).
- LATCH: latch=1 for exactly 2*HALF_CYCLES cycles, then go to LOW with bit index 0.
- LOW: nes_clk=0 for HALF_CYCLES cycles.
  - On the last LOW cycle, the synchronized data is written into shift[bit index].
  - Then go to HIGH.
- HIGH: nes_clk=1 for HALF_CYCLES cycles.
  - On exit, if bit index=7 go to DONE; otherwise increment bit index and go to LOW.
  - Exactly 8 nes_clk rising edges per transaction.
- DONE (1 cycle):
  - buttons <= shift, or ~shift if ACTIVE_LOW=1.
  - valid=1 for this cycle only.
  - Return to IDLE; the poll counter restarts from 0.
- busy=1 in LATCH, LOW, HIGH and DONE; busy=0 in IDLE.
- Transaction length from first latch=1 cycle to the valid cycle inclusive: 18*HALF_CYCLES+1 clocks.
- Automatic poll spacing between successive first-latch cycles: POLL_CYCLES+18*HALF_CYCLES+2 clocks.
- latch and nes_clk are never high at the same time. nes_clk is 0 in IDLE, LATCH and DONE.
- Synchronizer latency: the sampled bit is the value of data 2 clocks before the sample edge. HALF_CYCLES >= 4 guarantees the pad's output has settled.
- poll_en deasserted mid-transaction does not abort; the transaction completes.
- buttons holds its value between transactions.

Test Plan:
- Reset: assert reset mid-LOW of bit 3 (HALF_CYCLES=4) -> latch=0, nes_clk=0, busy=0, buttons=00 within the same cycle; no valid pulse follows.
- Single poll: HALF_CYCLES=4, poll_en=0, poll_now pulse; pad model loaded A=1, start=1, left=1.
  - latch high 8 clocks, then 8 nes_clk pulses of 4 low/4 high.
  - valid 73 clocks after the first latch cycle, with buttons=8'h49.
  - busy drops the cycle after valid.
- Periodic polling: POLL_CYCLES=20, HALF_CYCLES=4, poll_en=1, pad pattern 8'hA5 -> first-latch cycles spaced 94 clocks apart; every valid carries buttons=8'hA5.
- Inversion: ACTIVE_LOW=1, pad drives 8'hFE (only A low) -> buttons=8'h01.
- Collisions: poll_now on the same cycle the timer expires -> exactly one latch pulse. poll_now during busy -> no second transaction after DONE until the timer expires.
- Pattern change between polls: first poll returns 8'h00; pad changes to 8'h80 (right) -> second poll returns 8'h80; buttons holds 8'h00 until that valid.
